// File: rtl/lc4_multiplier_seq.sv
// Sequential unsigned 16x16 shift-and-add multiplier for the LC4 MUL path.
// It retires BITS_PER_CYCLE multiplier bits per clock and registers the full 32-bit product.
module lc4_multiplier_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_multiplicand,
    input  logic [15:0] i_multiplier,
    output logic        o_busy,
    output logic        o_valid,
    output logic [15:0] o_product,
    output logic [15:0] o_product_hi,
    output logic        o_overflow
);

    localparam int ITERS = 16 / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [31:0]    mcand_q;
    logic [15:0]    mplier_q;
    logic [31:0]    acc_q;
    logic [31:0]    acc_sum;
    logic [31:0]    partial;
    logic [CW-1:0]  iter_q;
    logic           done;

    // The accumulator cannot overflow: 0xFFFF * 0xFFFF still fits in 32 bits.
    always_comb begin
        partial    = mcand_q * {{(32 - BITS_PER_CYCLE){1'b0}}, mplier_q[BITS_PER_CYCLE-1:0]};
        acc_sum    = acc_q + partial;
        done       = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (iter_q == LAST) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            iter_q       <= '0;
            o_valid      <= 1'b0;
            o_product    <= '0;
            o_product_hi <= '0;
            o_overflow   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        mcand_q  <= {16'h0000, i_multiplicand};
                        mplier_q <= i_multiplier;
                        acc_q    <= '0;
                        iter_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    iter_q   <= iter_q + 1'b1;
                    if (done) begin
                        o_product    <= acc_sum[15:0];
                        o_product_hi <= acc_sum[31:16];
                        o_overflow   <= |acc_sum[31:16];
                        o_valid      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state == RUN);

endmodule

// File: tb/tb_lc4_multiplier_seq.sv
// Self-checking bench for lc4_multiplier_seq at BITS_PER_CYCLE = 1, 2 and 4.
// It uses directed table vectors, handshake corner sequences and a random product sweep.
module tb_lc4_multiplier_seq;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start;
    logic [15:0] a_in [3];
    logic [15:0] b_in [3];
    logic [2:0]  busy;
    logic [2:0]  valid;
    logic [15:0] lo [3];
    logic [15:0] hi [3];
    logic [2:0]  ovf;

    int vectors;
    int miscompares;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lc4_multiplier_seq #(.BITS_PER_CYCLE(1 << g)) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_start        (start[g]),
            .i_multiplicand (a_in[g]),
            .i_multiplier   (b_in[g]),
            .o_busy         (busy[g]),
            .o_valid        (valid[g]),
            .o_product      (lo[g]),
            .o_product_hi   (hi[g]),
            .o_overflow     (ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];
    int   iters_of [3] = '{16, 8, 4};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start[k] = 1'b1;
        a_in[k]  = a;
        b_in[k]  = b;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    // Launch one multiply, then time it and verify the handshake around it.
    task automatic runOp(input int k, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [31:0] prod, output logic ov);
        int drops;
        applyStimulus(k, a, b);
        checkOutput("busy_after_accept", 32'(busy[k]), 32'd1);
        lat   = 0;
        drops = 0;
        while (!valid[k] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!valid[k] && !busy[k]) drops++;
        end
        prod = {hi[k], lo[k]};
        ov   = ovf[k];
        checkOutput("busy_during_run", 32'(drops), 32'd0);
        checkOutput("busy_at_valid", 32'(busy[k]), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("valid_one_cycle", 32'(valid[k]), 32'd0);
    endtask

    initial begin
        int          lat;
        int          n;
        int          nvalid;
        logic [31:0] prod;
        logic [31:0] exp_prod;
        logic [31:0] seen;
        logic        ov;
        logic [15:0] ra;
        logic [15:0] rb;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = '0;
        for (int k = 0; k < 3; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end

        vecs[0] = '{0, 16'h0003, 16'h0005, 32'h0000_000F, 1'b0};
        vecs[1] = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1};
        vecs[2] = '{0, 16'h0100, 16'h0100, 32'h0001_0000, 1'b1};
        vecs[3] = '{0, 16'h0000, 16'hABCD, 32'h0000_0000, 1'b0};
        vecs[4] = '{0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0};
        vecs[5] = '{1, 16'h1234, 16'h0002, 32'h0000_2468, 1'b0};
        vecs[6] = '{1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1};
        vecs[7] = '{2, 16'h0007, 16'h0009, 32'h0000_003F, 1'b0};
        vecs[8] = '{2, 16'hABCD, 16'h0010, 32'h000A_BCD0, 1'b1};
        vecs[9] = '{2, 16'h8000, 16'h0002, 32'h0001_0000, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_busy", 32'(busy[k]), 32'd0);
            checkOutput("reset_valid", 32'(valid[k]), 32'd0);
            checkOutput("reset_product", {hi[k], lo[k]}, 32'd0);
            checkOutput("reset_overflow", 32'(ovf[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].inst, vecs[i].a, vecs[i].b, lat, prod, ov);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(iters_of[vecs[i].inst]));
            checkOutput($sformatf("vec%0d_product", i), prod, vecs[i].prod);
            checkOutput($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].ovf));
        end

        // A second start five cycles into a run must be dropped entirely.
        applyStimulus(0, 16'h1234, 16'h0002);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        start[0] = 1'b1;
        a_in[0]  = 16'h7777;
        b_in[0]  = 16'h7777;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        nvalid   = 0;
        seen     = '0;
        for (int c = 0; c < 40; c++) begin
            if (valid[0]) begin
                nvalid++;
                if (nvalid == 1) seen = {hi[0], lo[0]};
            end
            @(posedge clk);
            #1;
        end
        checkOutput("busy_ignore_valid_count", 32'(nvalid), 32'd1);
        checkOutput("busy_ignore_product", seen, 32'h0000_2468);

        // Restart during the valid cycle; the old result must hold until the new one lands.
        applyStimulus(0, 16'h0007, 16'h0009);
        n = 0;
        while (!valid[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b_first_latency", 32'(n), 32'd16);
        checkOutput("b2b_first_product", {hi[0], lo[0]}, 32'h0000_003F);
        start[0] = 1'b1;
        a_in[0]  = 16'h0000;
        b_in[0]  = 16'hABCD;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        n = 1;
        checkOutput("b2b_accepted_busy", 32'(busy[0]), 32'd1);
        while (!valid[0] && n < 40) begin
            if (n == 8) checkOutput("b2b_hold_product", {hi[0], lo[0]}, 32'h0000_003F);
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b_second_latency", 32'(n), 32'd17);
        checkOutput("b2b_second_product", {hi[0], lo[0]}, 32'h0000_0000);
        checkOutput("b2b_second_overflow", 32'(ovf[0]), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-run must clear a nonzero held result and kill the operation.
        runOp(0, 16'hFFFF, 16'hFFFF, lat, prod, ov);
        checkOutput("pre_reset_product", prod, 32'hFFFE_0001);
        applyStimulus(0, 16'h00FF, 16'h00FF);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", 32'(busy[0]), 32'd0);
        checkOutput("async_reset_product", {hi[0], lo[0]}, 32'd0);
        checkOutput("async_reset_overflow", 32'(ovf[0]), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (valid[0]) nvalid++;
        end
        checkOutput("async_reset_no_valid", 32'(nvalid), 32'd0);
        runOp(0, 16'h00FF, 16'h00FF, lat, prod, ov);
        checkOutput("post_reset_latency", 32'(lat), 32'd16);
        checkOutput("post_reset_product", prod, 32'h0000_FE01);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ((k == 0) ? 2000 : 1000); i++) begin
                ra       = 16'($urandom);
                rb       = 16'($urandom);
                exp_prod = {16'h0000, ra} * {16'h0000, rb};
                runOp(k, ra, rb, lat, prod, ov);
                checkOutput($sformatf("rand_bpc%0d_latency", 1 << k), 32'(lat), 32'(iters_of[k]));
                checkOutput($sformatf("rand_bpc%0d_%04h_x_%04h", 1 << k, ra, rb), prod, exp_prod);
                checkOutput($sformatf("rand_bpc%0d_overflow", 1 << k), 32'(ov), 32'(exp_prod[31:16] != 16'h0000));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
